// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
//   Physical-register free list organised as a circular FIFO of DEPTH entries.
//   A speculative head feeds dispatch (up to 3 PRs per cycle), an architectural
//   head follows retirement, and the tail receives the Told of retiring
//   instructions (up to 3 per cycle). On precise-state recovery the speculative
//   head snaps back to the architectural head, returning every PR handed out
//   since the last retirement point.
//
// Ports
//   clock             in   1         system clock, rising edge
//   reset             in   1         asynchronous, active-low
//   new_pr_en         in   3         dispatch way i consumes a PR (way 2 oldest)
//   free_pr           out  3xPR      PR offered to each way (combinational)
//   free_pr_valid     out  3         way i may assert new_pr_en[i]
//   retire_en         in   3         retiring way i returns its Told
//   retire_told       in   3xPR      Told of retiring way i
//   precise_state     in   1         recovery: head <= architectural head
//   fl_array_display  out  DEPTHxPR  FIFO contents (debug)
//   fl_head_display   out  PR        speculative head index (debug)
//   fl_tail_display   out  PR        tail index (debug)
//   fl_empty_display  out  1         list holds no free PR (debug)
// -----------------------------------------------------------------------------
module free_list #(
    parameter int PR    = 6,
    parameter int ARCH  = 32,
    parameter int DEPTH = 2**PR - ARCH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            new_pr_en,
    output logic [3*PR-1:0]       free_pr,
    output logic [2:0]            free_pr_valid,
    input  logic [2:0]            retire_en,
    input  logic [3*PR-1:0]       retire_told,
    input  logic                  precise_state,
    output logic [DEPTH*PR-1:0]   fl_array_display,
    output logic [PR-1:0]         fl_head_display,
    output logic [PR-1:0]         fl_tail_display,
    output logic                  fl_empty_display
);

    // DEPTH is a power of two, so index arithmetic wraps by truncation and the
    // extra pointer bit separates full from empty.
    localparam int IDXW = $clog2(DEPTH);
    localparam int PTRW = IDXW + 1;

    function automatic logic [1:0] popcnt3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

    logic [PTRW-1:0] r_head;        // speculative head (dispatch)
    logic [PTRW-1:0] r_arch_head;   // architectural head (retire)
    logic [PTRW-1:0] r_tail;        // next write position (retire push)
    logic [PR-1:0]   r_entry [DEPTH];

    logic [PTRW-1:0] w_count;
    logic [1:0]      w_pop_n;
    logic [1:0]      w_push_n;
    logic [1:0]      w_pop_off  [3];
    logic [1:0]      w_push_off [3];
    logic [IDXW-1:0] w_pop_idx  [3];
    logic [IDXW-1:0] w_push_idx [3];

    // Slot assignment. Enabled ways are compressed from way 2 downward onto
    // head, head+1, ... so the oldest consumer always gets the oldest PR.
    // Idle ways take the slots after the enabled ones, which keeps the three
    // offers distinct (an idle cycle offers head, head+1, head+2).
    // NOTE: every always_comb output gets a value before any branch; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        w_pop_n  = popcnt3(new_pr_en);
        w_push_n = popcnt3(retire_en);
        w_count  = r_tail - r_head;

        w_pop_off[2] = new_pr_en[2] ? 2'd0 : w_pop_n;
        w_pop_off[1] = new_pr_en[1] ? 2'(new_pr_en[2])
                                    : w_pop_n + 2'(!new_pr_en[2]);
        w_pop_off[0] = new_pr_en[0] ? popcnt3({1'b0, new_pr_en[2:1]})
                                    : w_pop_n + popcnt3({1'b0, ~new_pr_en[2:1]});

        // Retire writes are compressed the same way: way 2 lands at the tail.
        w_push_off[2] = 2'd0;
        w_push_off[1] = 2'(retire_en[2]);
        w_push_off[0] = popcnt3({1'b0, retire_en[2:1]});

        for (int i = 0; i < 3; i++) begin
            w_pop_idx[i]  = r_head[IDXW-1:0] + IDXW'(w_pop_off[i]);
            w_push_idx[i] = r_tail[IDXW-1:0] + IDXW'(w_push_off[i]);
        end
    end

    // Offers read the registered array only: a PR pushed this cycle becomes
    // offerable next cycle. With count == 0 every valid is low.
    always_comb begin
        free_pr       = '0;
        free_pr_valid = '0;
        for (int i = 0; i < 3; i++) begin
            free_pr[i*PR +: PR] = r_entry[w_pop_idx[i]];
            free_pr_valid[i]    = w_count > PTRW'(w_pop_off[i]);
        end
    end

    // NOTE: state registers use non-blocking assignments so every pointer and
    // entry updates from the same pre-edge values.
    // NOTE: the array is reset because its reset contents are the initial free
    // PRs (ARCH .. ARCH+DEPTH-1); it is state, not scratch storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head      <= '0;
            r_arch_head <= '0;
            r_tail      <= PTRW'(DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= PR'(ARCH + i);
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (retire_en[i]) begin
                    r_entry[w_push_idx[i]] <= retire_told[i*PR +: PR];
                end
            end
            r_tail      <= r_tail + PTRW'(w_push_n);
            r_arch_head <= r_arch_head + PTRW'(w_push_n);
            // Recovery counts this cycle's retirements and ignores dispatch.
            if (precise_state) begin
                r_head <= r_arch_head + PTRW'(w_push_n);
            end else begin
                r_head <= r_head + PTRW'(w_pop_n);
            end
        end
    end

    always_comb begin
        fl_array_display = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fl_array_display[i*PR +: PR] = r_entry[i];
        end
    end

    assign fl_head_display  = PR'(r_head[IDXW-1:0]);
    assign fl_tail_display  = PR'(r_tail[IDXW-1:0]);
    assign fl_empty_display = (w_count == '0);

endmodule
